// File: rtl/channel_retr_sequencer_pkg.sv
// Shared constants, helper functions and FSM encoding for the channel
// retrieval sequencer slice.
package channel_retr_sequencer_pkg;

  localparam int INPUT_CHANNELS        = 4;
  localparam int DEFAULT_MOD1_CHANNELS = INPUT_CHANNELS;
  localparam int DEFAULT_MOD2_CHANNELS = INPUT_CHANNELS;
  localparam int DEFAULT_MOD3_CHANNELS = INPUT_CHANNELS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  // Never returns 0, so a single-channel build still gets a 1-bit index.
  function automatic int ceilLog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/channel_index_counter.sv
// Saturating per-modality channel index: loads 0 on sweep start, advances on
// each accepted step and parks at LIMIT-1 once the modality runs out.
module channel_index_counter #(
  parameter int CH_WIDTH = 2,
  parameter int LIMIT    = 4
) (
  input  logic                Clk_CI,
  input  logic                Reset_RI,
  input  logic                Clear_SI,
  input  logic                Load_SI,
  input  logic                Step_SI,
  output logic [CH_WIDTH-1:0] Index_DO,
  output logic                ModValid_SO
);

  localparam logic [CH_WIDTH-1:0] LAST_INDEX = CH_WIDTH'(LIMIT - 1);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || Clear_SI) begin
      Index_DO    <= '0;
      ModValid_SO <= 1'b0;
    end else if (Load_SI) begin
      Index_DO    <= '0;
      ModValid_SO <= 1'b1;
    end else if (Step_SI && ModValid_SO) begin
      if (Index_DO == LAST_INDEX) begin
        ModValid_SO <= 1'b0;
      end else begin
        Index_DO <= Index_DO + CH_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/channel_retr_sequencer.sv
// Walks mod1/mod2/mod3 channel indices in lockstep for the retrieval lookup,
// one step per valid/ready handshake with the spatial encoder.
module channel_retr_sequencer
  import channel_retr_sequencer_pkg::*;
#(
  parameter int CH_WIDTH      = ceilLog2(INPUT_CHANNELS),
  parameter int MOD1_CHANNELS = DEFAULT_MOD1_CHANNELS,
  parameter int MOD2_CHANNELS = DEFAULT_MOD2_CHANNELS,
  parameter int MOD3_CHANNELS = DEFAULT_MOD3_CHANNELS
) (
  input  logic                Clk_CI,
  input  logic                Reset_RI,
  input  logic                Start_SI,
  input  logic                Clear_SI,
  output logic                Idle_SO,
  output logic                ChannelValid_SO,
  input  logic                ChannelReady_SI,
  output logic [CH_WIDTH-1:0] channel_mod1_DO,
  output logic [CH_WIDTH-1:0] channel_mod2_DO,
  output logic [CH_WIDTH-1:0] channel_mod3_DO,
  output logic [2:0]          ModValid_SO,
  output logic                FirstChannel_SO,
  output logic                LastChannel_SO,
  output logic [CH_WIDTH-1:0] StepCount_SO,
  output logic                Done_SO
);

  localparam int                  MAXCH     = maxOf3(MOD1_CHANNELS, MOD2_CHANNELS, MOD3_CHANNELS);
  localparam logic [CH_WIDTH-1:0] LAST_STEP = CH_WIDTH'(MAXCH - 1);

  if (MOD1_CHANNELS < 1 || MOD1_CHANNELS > (1 << CH_WIDTH) ||
      MOD2_CHANNELS < 1 || MOD2_CHANNELS > (1 << CH_WIDTH) ||
      MOD3_CHANNELS < 1 || MOD3_CHANNELS > (1 << CH_WIDTH)) begin : gBadChannelCount
    $fatal(1, "channel_retr_sequencer: channel count outside 1..2**CH_WIDTH");
  end

  seqState_t           stateQ, stateD;
  logic [CH_WIDTH-1:0] stepD;
  logic                validD, firstD, lastD, doneD;
  logic                loadIdx, stepIdx, flushIdx;
  logic                handshake;

  assign handshake = ChannelValid_SO & ChannelReady_SI;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    stateD   = stateQ;
    stepD    = StepCount_SO;
    validD   = ChannelValid_SO;
    firstD   = FirstChannel_SO;
    lastD    = LastChannel_SO;
    doneD    = 1'b0;
    loadIdx  = 1'b0;
    stepIdx  = 1'b0;
    flushIdx = 1'b0;

    if (Clear_SI) begin
      // Abort wins over start and over a same-cycle handshake.
      stateD   = IDLE;
      stepD    = '0;
      validD   = 1'b0;
      firstD   = 1'b0;
      lastD    = 1'b0;
      flushIdx = 1'b1;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (Start_SI) begin
            stateD  = RUN;
            stepD   = '0;
            validD  = 1'b1;
            firstD  = 1'b1;
            lastD   = (MAXCH == 1);
            loadIdx = 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            if (StepCount_SO == LAST_STEP) begin
              stateD   = DONE;
              stepD    = '0;
              validD   = 1'b0;
              firstD   = 1'b0;
              lastD    = 1'b0;
              doneD    = 1'b1;
              flushIdx = 1'b1;
            end else begin
              stepD   = StepCount_SO + CH_WIDTH'(1);
              firstD  = 1'b0;
              lastD   = (stepD == LAST_STEP);
              stepIdx = 1'b1;
            end
          end
        end
        DONE:    stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      stateQ          <= IDLE;
      StepCount_SO    <= '0;
      ChannelValid_SO <= 1'b0;
      FirstChannel_SO <= 1'b0;
      LastChannel_SO  <= 1'b0;
      Done_SO         <= 1'b0;
      Idle_SO         <= 1'b1;
    end else begin
      stateQ          <= stateD;
      StepCount_SO    <= stepD;
      ChannelValid_SO <= validD;
      FirstChannel_SO <= firstD;
      LastChannel_SO  <= lastD;
      Done_SO         <= doneD;
      Idle_SO         <= (stateD == IDLE);
    end
  end

  channel_index_counter #(.CH_WIDTH(CH_WIDTH), .LIMIT(MOD1_CHANNELS)) u_mod1Counter (
    .Clk_CI      (Clk_CI),
    .Reset_RI    (Reset_RI),
    .Clear_SI    (flushIdx),
    .Load_SI     (loadIdx),
    .Step_SI     (stepIdx),
    .Index_DO    (channel_mod1_DO),
    .ModValid_SO (ModValid_SO[0])
  );

  channel_index_counter #(.CH_WIDTH(CH_WIDTH), .LIMIT(MOD2_CHANNELS)) u_mod2Counter (
    .Clk_CI      (Clk_CI),
    .Reset_RI    (Reset_RI),
    .Clear_SI    (flushIdx),
    .Load_SI     (loadIdx),
    .Step_SI     (stepIdx),
    .Index_DO    (channel_mod2_DO),
    .ModValid_SO (ModValid_SO[1])
  );

  channel_index_counter #(.CH_WIDTH(CH_WIDTH), .LIMIT(MOD3_CHANNELS)) u_mod3Counter (
    .Clk_CI      (Clk_CI),
    .Reset_RI    (Reset_RI),
    .Clear_SI    (flushIdx),
    .Load_SI     (loadIdx),
    .Step_SI     (stepIdx),
    .Index_DO    (channel_mod3_DO),
    .ModValid_SO (ModValid_SO[2])
  );

endmodule

// File: tb/tb_channel_retr_sequencer.sv
// Scoreboard bench: a 4/3/2-channel sequencer checked every cycle against a
// behavioural model, plus a directed single-step (all counts 1) instance.
module tb_channel_retr_sequencer;

  localparam int W  = 2;
  localparam int M1 = 4;
  localparam int M2 = 3;
  localparam int M3 = 2;
  localparam int MAXCH_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, clear, ready;
  logic startB, readyB;

  logic         idleA, validA, firstA, lastA, doneA;
  logic [W-1:0] m1A, m2A, m3A, stepA;
  logic [2:0]   mvA;

  logic         idleB, validB, firstB, lastB, doneB;
  logic [W-1:0] m1B, m2B, m3B, stepB;
  logic [2:0]   mvB;

  channel_retr_sequencer #(
    .CH_WIDTH(W), .MOD1_CHANNELS(M1), .MOD2_CHANNELS(M2), .MOD3_CHANNELS(M3)
  ) dutA (
    .Clk_CI(clk), .Reset_RI(reset), .Start_SI(start), .Clear_SI(clear),
    .Idle_SO(idleA), .ChannelValid_SO(validA), .ChannelReady_SI(ready),
    .channel_mod1_DO(m1A), .channel_mod2_DO(m2A), .channel_mod3_DO(m3A),
    .ModValid_SO(mvA), .FirstChannel_SO(firstA), .LastChannel_SO(lastA),
    .StepCount_SO(stepA), .Done_SO(doneA)
  );

  channel_retr_sequencer #(
    .CH_WIDTH(W), .MOD1_CHANNELS(1), .MOD2_CHANNELS(1), .MOD3_CHANNELS(1)
  ) dutB (
    .Clk_CI(clk), .Reset_RI(reset), .Start_SI(startB), .Clear_SI(1'b0),
    .Idle_SO(idleB), .ChannelValid_SO(validB), .ChannelReady_SI(readyB),
    .channel_mod1_DO(m1B), .channel_mod2_DO(m2B), .channel_mod3_DO(m3B),
    .ModValid_SO(mvB), .FirstChannel_SO(firstB), .LastChannel_SO(lastB),
    .StepCount_SO(stepB), .Done_SO(doneB)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] m1, m2, m3, step;
    logic [2:0]   mv;
    logic         first, last;
  } stepExp_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} modelState_t;

  stepExp_t    sb[$];
  modelState_t mState = M_IDLE;
  logic        monOn  = 1'b0;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic pushSweep();
    stepExp_t e;
    for (int s = 0; s < MAXCH_A; s++) begin
      e.step  = W'(s);
      e.m1    = W'(minInt(s, M1 - 1));
      e.m2    = W'(minInt(s, M2 - 1));
      e.m3    = W'(minInt(s, M3 - 1));
      e.mv    = {(s < M3), (s < M2), (s < M1)};
      e.first = (s == 0);
      e.last  = (s == MAXCH_A - 1);
      sb.push_back(e);
    end
  endtask

  // Compare dutA against the model on every falling edge, then advance the
  // model using the inputs that the next rising edge will sample.
  initial begin
    stepExp_t e;
    forever begin
      @(negedge clk);
      if (monOn) begin
        check("idle",  32'(idleA),  32'(mState == M_IDLE));
        check("valid", 32'(validA), 32'(mState == M_RUN));
        check("done",  32'(doneA),  32'(mState == M_DONE));
        if (mState == M_RUN) begin
          e = sb[0];
          check("mod1",  32'(m1A),    32'(e.m1));
          check("mod2",  32'(m2A),    32'(e.m2));
          check("mod3",  32'(m3A),    32'(e.m3));
          check("step",  32'(stepA),  32'(e.step));
          check("modv",  32'(mvA),    32'(e.mv));
          check("first", 32'(firstA), 32'(e.first));
          check("last",  32'(lastA),  32'(e.last));
        end
        if (clear) begin
          sb.delete();
          mState = M_IDLE;
        end else begin
          case (mState)
            M_IDLE: if (start) begin pushSweep(); mState = M_RUN; end
            M_RUN: if (ready) begin
              e = sb.pop_front();
              mState = e.last ? M_DONE : M_RUN;
            end
            default: mState = M_IDLE;
          endcase
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; ready = 1'b1;
    startB = 1'b0; readyB = 1'b1;
    tick(2);
    reset = 1'b0;
    monOn = 1'b1;
    tick(5);

    // Plain sweep, ready held high.
    start = 1'b1; tick(); start = 1'b0;
    tick(8);

    // Three stall cycles while step 1 is presented.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ready = 1'b0; tick(3); ready = 1'b1;
    tick(8);

    // Abort together with the step-2 handshake, then restart.
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    clear = 1'b1; tick(); clear = 1'b0;
    tick(3);
    start = 1'b1; tick(); start = 1'b0;
    tick(8);

    // Start held through RUN and DONE: back-to-back sweeps.
    start = 1'b1; tick(14); start = 1'b0;
    tick(8);

    // Randomised backpressure.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    tick(10);

    // Single-step configuration: First and Last on the only step.
    check("b_idle0", 32'(idleB), 32'd1);
    startB = 1'b1; tick(); startB = 1'b0;
    check("b_valid", 32'(validB), 32'd1);
    check("b_first", 32'(firstB), 32'd1);
    check("b_last",  32'(lastB),  32'd1);
    check("b_modv",  32'(mvB),    32'b111);
    check("b_idx",   32'({m1B, m2B, m3B, stepB}), 32'd0);
    check("b_done0", 32'(doneB),  32'd0);
    tick();
    check("b_done1", 32'(doneB),  32'd1);
    check("b_vld1",  32'(validB), 32'd0);
    check("b_modv1", 32'(mvB),    32'b000);
    check("b_idle1", 32'(idleB),  32'd0);
    tick();
    check("b_done2", 32'(doneB),  32'd0);
    check("b_idle2", 32'(idleB),  32'd1);

    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
